// File: rtl/computing_arbiter.sv
// Round-robin arbiter sharing one computing device (adder/compare slave) among NUM_REQ requesters.
// Latency: request seen in IDLE at cycle R -> device enable at R+1 -> ack/rdata at R+2+DEV_LATENCY.
// Backpressure: one transaction in flight; other requesters hold req until ack (level request, one-cycle ack).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req[NUM_REQ]             level requests; req_addr/req_wdata packed per requester
//                            (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   ack[NUM_REQ], rdata      one-hot completion pulse and its result (rdata 0 otherwise)
//   busy                     high whenever a transaction is in progress
//   device_en, dev_address,  device bus, driven only in the issue cycle and 0 otherwise
//   dev_wdata, dev_rdata     because the slave buses are OR-combined
module computing_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int DEV_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          device_en,
  output logic [DATA_WIDTH-1:0]         dev_address,
  output logic [DATA_WIDTH-1:0]         dev_wdata,
  input  logic [DATA_WIDTH-1:0]         dev_rdata
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   NREQ = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        grant;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_vld;
  logic [PTR_W:0]          pos;
  logic [3:0]              lat_cnt;
  logic [DATA_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH-1:0]   result;

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... with wrap. Scanning from the far
  // end down lets the closest set bit overwrite earlier hits, so no loop exit is needed.
  // The explicit subtract handles non-power-of-2 NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pos      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (req[pos[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = pos[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs. All bus outputs default to 0 outside their own state.
  always_comb begin
    state_nxt   = state;
    ack         = '0;
    rdata       = '0;
    busy        = (state != IDLE);
    device_en   = 1'b0;
    dev_address = '0;
    dev_wdata   = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        device_en   = 1'b1;
        dev_address = lat_addr;
        dev_wdata   = lat_wdata;
        state_nxt   = WAIT;
      end
      WAIT: begin
        // <= 1 rather than == 1 so a corrupted count can never stall the arbiter
        if (lat_cnt <= 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        ack[grant] = 1'b1;
        rdata      = result;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operands are captured at grant so the requester may change or drop
  // its inputs afterwards without disturbing the in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant     <= '0;
      lat_cnt   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      result    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant     <= pick_idx;
            lat_addr  <= req_addr[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            lat_wdata <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ISSUE: begin
          lat_cnt <= 4'(DEV_LATENCY);
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          // counter at 1 means DEV_LATENCY cycles have passed since the issue cycle
          if (lat_cnt <= 4'd1) begin
            result <= dev_rdata;
          end
        end
        RESP: begin
          rr_ptr <= (grant == LAST) ? '0 : grant + PTR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
